// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a multi-digit common-anode 7-segment display.
// One nibble is presented per slot to a shared hex decoder. Each slot
// starts with a short dark window to stop ghosting between digits.
// New values are double-buffered and only swapped in at a frame boundary.
module seg7_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int BLANK  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_en,
    output logic [3:0]            nib,
    output logic                  seg_blank,
    output logic [DIGITS-1:0]     an_n,
    output logic                  dp_n,
    output logic                  frame_tick
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

    typedef enum logic {
        PH_DARK,
        PH_SHOW
    } phase_t;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] active;
    logic [DIGITS-1:0]   dp_active;
    logic [4*DIGITS-1:0] shadow;
    logic [DIGITS-1:0]   dp_shadow;
    logic                pending;

    logic                wrap;
    phase_t              phase;
    logic [DIGITS-1:0]   suppress;
    logic                all_zero;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_sup;

    assign wrap = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // The first BLANK cycles of every slot are dark, the rest may light the digit
    always_comb begin
        phase = (cnt < CNT_BLANK) ? PH_DARK : PH_SHOW;
    end

    // A digit is suppressed when it and every digit to its left are zero (never digit 0)
    always_comb begin
        suppress = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero    = all_zero && (active[4*i +: 4] == 4'd0);
            suppress[i] = lz_en && all_zero;
        end
    end

    // Select the nibble, decimal point and suppression flag of the digit being scanned
    always_comb begin
        cur_nib = 4'd0;
        cur_dp  = 1'b0;
        cur_sup = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = active[4*i +: 4];
                cur_dp  = dp_active[i];
                cur_sup = suppress[i];
            end
        end
    end

    // Free-running slot counter and digit index; the index wraps to start a new frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: loads land in the shadow and move to active only on a frame wrap,
    // except a load on the wrap cycle itself, which goes straight to active
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= '0;
            dp_active <= '0;
            shadow    <= '0;
            dp_shadow <= '0;
            pending   <= 1'b0;
        end else if (load && wrap) begin
            active    <= value;
            dp_active <= dp_in;
            pending   <= 1'b0;
        end else if (load) begin
            shadow    <= value;
            dp_shadow <= dp_in;
            pending   <= 1'b1;
        end else if (wrap && pending) begin
            active    <= shadow;
            dp_active <= dp_shadow;
            pending   <= 1'b0;
        end
    end

    // Registered display outputs derived from this cycle's slot position and active data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nib        <= 4'd0;
            seg_blank  <= 1'b1;
            an_n       <= '1;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            nib        <= cur_nib;
            frame_tick <= wrap;
            if (phase == PH_SHOW && !cur_sup) begin
                an_n      <= ~(DIGITS'(1) << idx);
                seg_blank <= 1'b0;
                dp_n      <= ~cur_dp;
            end else begin
                an_n      <= '1;
                seg_blank <= 1'b1;
                dp_n      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with DIGITS=4, DIV=8, BLANK=2.
// A time-indexed reference model predicts every output each cycle; a few
// hand-worked expectations pin the model to known display sequences.
module tb_seg7_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int DIV    = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * DIV;

    logic                  clk;
    logic                  rst;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  lz_en;
    logic [3:0]            nib;
    logic                  seg_blank;
    logic [DIGITS-1:0]     an_n;
    logic                  dp_n;
    logic                  frame_tick;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    // model state: t is the index of the next rising edge since reset release
    int                  t;
    logic [4*DIGITS-1:0] m_active, m_shadow;
    logic [DIGITS-1:0]   m_dp_active, m_dp_shadow;
    bit                  m_pending;
    logic [3:0]          e_nib;
    logic                e_blank;
    logic [DIGITS-1:0]   e_an;
    logic                e_dp;
    logic                e_tick;

    seg7_scan_ctrl #(
        .DIGITS(DIGITS),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .value     (value),
        .dp_in     (dp_in),
        .lz_en     (lz_en),
        .nib       (nib),
        .seg_blank (seg_blank),
        .an_n      (an_n),
        .dp_n      (dp_n),
        .frame_tick(frame_tick)
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: slot, phase and frame position come straight from elapsed cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t           = 0;
            m_active    = '0;
            m_shadow    = '0;
            m_dp_active = '0;
            m_dp_shadow = '0;
            m_pending   = 0;
            e_nib       = 4'd0;
            e_blank     = 1'b1;
            e_an        = '1;
            e_dp        = 1'b1;
            e_tick      = 1'b0;
        end else begin
            int  slot;
            int  pos;
            bit  sup;
            bit  lit;
            bit  wrap_now;
            slot     = (t / DIV) % DIGITS;
            pos      = t % DIV;
            wrap_now = ((t % FRAME) == FRAME - 1);
            sup      = lz_en && (slot != 0) && ((m_active >> (4 * slot)) == 0);
            lit      = (pos >= BLANK) && !sup;
            e_nib    = 4'((m_active >> (4 * slot)) & 16'hF);
            e_an     = lit ? ~(DIGITS'(1) << slot) : '1;
            e_blank  = !lit;
            e_dp     = lit ? ~m_dp_active[slot] : 1'b1;
            e_tick   = wrap_now;
            if (load && wrap_now) begin
                m_active    = value;
                m_dp_active = dp_in;
                m_pending   = 0;
            end else if (load) begin
                m_shadow    = value;
                m_dp_shadow = dp_in;
                m_pending   = 1;
            end else if (wrap_now && m_pending) begin
                m_active    = m_shadow;
                m_dp_active = m_dp_shadow;
                m_pending   = 0;
            end
            t++;
        end
    end

    // Every cycle, once enabled, all outputs must match the model
    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("nib",        32'(nib),        32'(e_nib));
            checkOutput("seg_blank",  32'(seg_blank),  32'(e_blank));
            checkOutput("an_n",       32'(an_n),       32'(e_an));
            checkOutput("dp_n",       32'(dp_n),       32'(e_dp));
            checkOutput("frame_tick", 32'(frame_tick), 32'(e_tick));
        end
    end

    task automatic applyStimulus(input logic ld, input logic [4*DIGITS-1:0] v,
                                 input logic [DIGITS-1:0] dp, input logic lz);
        load  = ld;
        value = v;
        dp_in = dp;
        lz_en = lz;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Advance until the outputs on display reflect model cycle 'target'
    task automatic waitUntil(input int target);
        for (int k = 0; k < 5000 && t != target + 1; k++) @(negedge clk);
        if (t != target + 1) checkOutput("wait_timeout", 32'(t), 32'(target + 1));
    endtask

    initial begin
        load  = 1'b0;
        value = '0;
        dp_in = '0;
        lz_en = 1'b0;
        rst   = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_an_n",      32'(an_n),      32'hF);
        checkOutput("reset_seg_blank", 32'(seg_blank), 32'h1);
        cmp_en = 1;
        rst = 1'b0;

        // after release: two dark cycles then digit 0 showing 0
        waitUntil(0);
        checkOutput("slot0_dark_an",  32'(an_n), 32'hF);
        waitUntil(2);
        checkOutput("slot0_show_an",  32'(an_n), 32'hE);
        checkOutput("slot0_show_nib", 32'(nib),  32'h0);

        // 12AF with dp on digit 2 becomes visible from the next frame
        applyStimulus(1'b1, 16'h12AF, 4'b0100, 1'b0);
        waitUntil(34);
        checkOutput("d0_nib", 32'(nib),  32'hF);
        checkOutput("d0_an",  32'(an_n), 32'hE);
        checkOutput("d0_dp",  32'(dp_n), 32'h1);
        waitUntil(42);
        checkOutput("d1_nib", 32'(nib),  32'hA);
        checkOutput("d1_an",  32'(an_n), 32'hD);
        waitUntil(50);
        checkOutput("d2_nib", 32'(nib),  32'h2);
        checkOutput("d2_an",  32'(an_n), 32'hB);
        checkOutput("d2_dp",  32'(dp_n), 32'h0);

        // leading-zero suppression of 0050
        applyStimulus(1'b1, 16'h0050, 4'b0000, 1'b1);
        waitUntil(66);
        checkOutput("lz_d0_nib", 32'(nib),  32'h0);
        checkOutput("lz_d0_an",  32'(an_n), 32'hE);
        waitUntil(76);
        checkOutput("lz_d1_nib", 32'(nib),  32'h5);
        checkOutput("lz_d1_an",  32'(an_n), 32'hD);
        waitUntil(92);
        checkOutput("lz_d3_an",    32'(an_n),      32'hF);
        checkOutput("lz_d3_blank", 32'(seg_blank), 32'h1);

        // tear-free swap: 3333 loaded mid-frame only shows from the next frame
        applyStimulus(1'b1, 16'h12AF, 4'b0000, 1'b0);
        waitUntil(106);
        applyStimulus(1'b1, 16'h3333, 4'b0000, 1'b0);
        waitUntil(114);
        checkOutput("tear_d2_nib", 32'(nib), 32'h2);
        waitUntil(122);
        checkOutput("tear_d3_nib", 32'(nib), 32'h1);
        waitUntil(127);
        checkOutput("tear_tick", 32'(frame_tick), 32'h1);
        waitUntil(130);
        checkOutput("tear_new_nib", 32'(nib), 32'h3);

        // load on the wrap cycle goes straight to the new frame
        waitUntil(158);
        applyStimulus(1'b1, 16'h4567, 4'b0000, 1'b0);
        waitUntil(162);
        checkOutput("wrapload_nib", 32'(nib),  32'h7);
        checkOutput("wrapload_an",  32'(an_n), 32'hE);

        // reset mid-show of digit 2 with a pending load
        waitUntil(177);
        applyStimulus(1'b1, 16'h9999, 4'b1111, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_an",    32'(an_n),      32'hF);
        checkOutput("midrst_blank", 32'(seg_blank), 32'h1);
        checkOutput("midrst_dp",    32'(dp_n),      32'h1);
        checkOutput("midrst_nib",   32'(nib),       32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        waitUntil(34);
        checkOutput("postrst_nib", 32'(nib),  32'h0);
        checkOutput("postrst_an",  32'(an_n), 32'hE);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [4*DIGITS-1:0] v;
            logic                lz;
            v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
            lz = ($urandom_range(0, 39) == 0) ? ~lz_en : lz_en;
            applyStimulus($urandom_range(0, 5) == 0, v, 4'($urandom), lz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
